autoconfig_host_scanner: RTL and testbench

// - Host-side AutoConfig initiator: the other end of the card's AutoConfig responder.
// - Reads a Zorro III card's config nibbles 0x00-0x13 and de-inverts them into ER fields.
// - Then either writes the assigned base nibble, which configures the card,
//   or writes shutup. Sits between the bench/host bus model and the card's config-space port.

---
 rtl/autoconfig_host_scanner_pkg.sv | 32 +++
 rtl/autoconfig_host_scanner_if.sv | 29 ++
 rtl/autoconfig_host_scanner_ac_access_timer.sv | 30 +++
 rtl/autoconfig_host_scanner.sv | 235 +++++++++++++++++++++++
 tb/tb_autoconfig_host_scanner.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/autoconfig_host_scanner_pkg.sv
// Shared types and constants for the host-side AutoConfig scanner.
package autoconfig_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHK,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_DECIDE,
        ST_WR_REQ,
        ST_WR_WAIT,
        ST_FIN
    } scan_state_t;

    localparam logic [6:0] NIB_TYPE  = 7'd0;
    localparam logic [6:0] NIB_PROD  = 7'd2;
    localparam logic [6:0] NIB_FLAGS = 7'd4;
    localparam logic [6:0] NIB_MFG   = 7'd8;
    localparam logic [6:0] NIB_SER   = 7'd12;
    localparam logic [6:0] NIB_LAST  = 7'd19;

    localparam logic [6:0] ADDRL_BASE   = 7'h11;
    localparam logic [6:0] ADDRL_SHUTUP = 7'h13;

    localparam logic [1:0] ER_TYPE_Z3 = 2'b10;

    // Serial nibble index to the card's ADDRL: LSB of the index selects the odd half.
    function automatic logic [6:0] nib_to_addrl(input logic [6:0] idx);
        return {idx[0], idx[6:1]};
    endfunction

endpackage

// File: rtl/autoconfig_host_scanner_if.sv
// Config-space access bus between the scanner (master) and the card responder (slave).
interface autoconfig_host_scanner_if;

    logic       bus_req;
    logic       bus_read;
    logic [6:0] bus_addrl;
    logic [3:0] bus_wdata;
    logic [3:0] bus_rdata;
    logic       bus_ack;

    modport master (
        output bus_req,
        output bus_read,
        output bus_addrl,
        output bus_wdata,
        input  bus_rdata,
        input  bus_ack
    );

    modport slave (
        input  bus_req,
        input  bus_read,
        input  bus_addrl,
        input  bus_wdata,
        output bus_rdata,
        output bus_ack
    );

endinterface

// File: rtl/autoconfig_host_scanner_ac_access_timer.sv
// Per-access ack timeout: reloads at each new request, counts through both handshake phases.
module ac_access_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic reload,
    input  logic count,
    output logic expired
);

    localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt;

    // Expiry flags the final allowed cycle so the caller leaves on that edge.
    assign expired = count && (cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (reload) begin
            cnt <= '0;
        end else if (count && !expired) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/autoconfig_host_scanner.sv
// Host AutoConfig initiator: reads a card's ER nibbles, then assigns its base or shuts it up.
module autoconfig_host_scanner
    import autoconfig_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [6:0]  LAST_NIBBLE    = NIB_LAST
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        start,
    input  logic [3:0]  base_nibble,
    input  logic        force_shutup,
    input  logic        cfgin_n,
    autoconfig_host_scanner_if.master bus,
    output logic        busy,
    output logic        done,
    output logic        card_present,
    output logic        configured,
    output logic        timeout_err,
    output logic [7:0]  er_type,
    output logic [7:0]  prod_id,
    output logic [7:0]  er_flags,
    output logic [15:0] mfg_id,
    output logic [31:0] serial
);

    scan_state_t state, state_nxt;

    logic [6:0] nib_idx;
    logic [3:0] base_q;
    logic       shutup_q;
    logic [6:0] wr_addrl;
    logic [3:0] wr_data;
    logic       wr_is_base;

    logic tmr_reload;
    logic tmr_count;
    logic tmr_expired;
    logic abort;
    logic capture;

    ac_access_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (CLK),
        .rst    (RESET),
        .reload (tmr_reload),
        .count  (tmr_count),
        .expired(tmr_expired)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        bus.bus_req    = 1'b0;
        bus.bus_read   = 1'b1;
        bus.bus_addrl  = '0;
        bus.bus_wdata  = '0;
        busy           = 1'b1;
        done           = 1'b0;
        tmr_reload     = 1'b0;
        tmr_count      = 1'b0;
        abort          = 1'b0;
        capture        = 1'b0;

        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = ST_CHK;
                end
            end
            ST_CHK: begin
                if (cfgin_n) begin
                    state_nxt = ST_FIN;
                end else begin
                    state_nxt  = ST_RD_REQ;
                    tmr_reload = 1'b1;
                end
            end
            ST_RD_REQ: begin
                bus.bus_req   = 1'b1;
                bus.bus_addrl = nib_to_addrl(nib_idx);
                tmr_count     = 1'b1;
                if (bus.bus_ack) begin
                    capture   = 1'b1;
                    state_nxt = ST_RD_WAIT;
                end else if (tmr_expired) begin
                    abort     = 1'b1;
                    state_nxt = ST_FIN;
                end
            end
            ST_RD_WAIT: begin
                bus.bus_addrl = nib_to_addrl(nib_idx);
                tmr_count     = 1'b1;
                if (!bus.bus_ack) begin
                    if (nib_idx == LAST_NIBBLE) begin
                        state_nxt = ST_DECIDE;
                    end else begin
                        state_nxt  = ST_RD_REQ;
                        tmr_reload = 1'b1;
                    end
                end else if (tmr_expired) begin
                    abort     = 1'b1;
                    state_nxt = ST_FIN;
                end
            end
            ST_DECIDE: begin
                state_nxt  = ST_WR_REQ;
                tmr_reload = 1'b1;
            end
            ST_WR_REQ: begin
                bus.bus_req   = 1'b1;
                bus.bus_read  = 1'b0;
                bus.bus_addrl = wr_addrl;
                bus.bus_wdata = wr_data;
                tmr_count     = 1'b1;
                if (bus.bus_ack) begin
                    state_nxt = ST_WR_WAIT;
                end else if (tmr_expired) begin
                    abort     = 1'b1;
                    state_nxt = ST_FIN;
                end
            end
            ST_WR_WAIT: begin
                bus.bus_read  = 1'b0;
                bus.bus_addrl = wr_addrl;
                bus.bus_wdata = wr_data;
                tmr_count     = 1'b1;
                if (!bus.bus_ack) begin
                    state_nxt = ST_FIN;
                end else if (tmr_expired) begin
                    abort     = 1'b1;
                    state_nxt = ST_FIN;
                end
            end
            ST_FIN: begin
                busy      = 1'b0;
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            nib_idx      <= '0;
            base_q       <= '0;
            shutup_q     <= 1'b0;
            wr_addrl     <= '0;
            wr_data      <= '0;
            wr_is_base   <= 1'b0;
            card_present <= 1'b0;
            configured   <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            if (state == ST_IDLE && start) begin
                base_q       <= base_nibble;
                shutup_q     <= force_shutup;
                card_present <= 1'b0;
                configured   <= 1'b0;
                timeout_err  <= 1'b0;
            end
            if (state == ST_CHK) begin
                nib_idx <= '0;
            end
            if (state == ST_RD_WAIT && !bus.bus_ack && nib_idx != LAST_NIBBLE) begin
                nib_idx <= nib_idx + 7'd1;
            end
            if (state == ST_DECIDE) begin
                card_present <= 1'b1;
                // Anything that is not a Zorro III board is shut up rather than mapped.
                if (shutup_q || er_type[7:6] != ER_TYPE_Z3) begin
                    wr_addrl   <= ADDRL_SHUTUP;
                    wr_data    <= '0;
                    wr_is_base <= 1'b0;
                end else begin
                    wr_addrl   <= ADDRL_BASE;
                    wr_data    <= base_q;
                    wr_is_base <= 1'b1;
                end
            end
            if (state == ST_WR_WAIT && !bus.bus_ack) begin
                configured <= wr_is_base;
            end
            if (abort) begin
                timeout_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            er_type  <= '0;
            prod_id  <= '0;
            er_flags <= '0;
            mfg_id   <= '0;
            serial   <= '0;
        end else if (capture) begin
            // Everything except the type byte is stored inverted on the card.
            case (nib_idx)
                NIB_TYPE:          er_type[7:4]   <= bus.bus_rdata;
                NIB_TYPE + 7'd1:   er_type[3:0]   <= bus.bus_rdata;
                NIB_PROD:          prod_id[7:4]   <= ~bus.bus_rdata;
                NIB_PROD + 7'd1:   prod_id[3:0]   <= ~bus.bus_rdata;
                NIB_FLAGS:         er_flags[7:4]  <= ~bus.bus_rdata;
                NIB_FLAGS + 7'd1:  er_flags[3:0]  <= ~bus.bus_rdata;
                NIB_MFG:           mfg_id[15:12]  <= ~bus.bus_rdata;
                NIB_MFG + 7'd1:    mfg_id[11:8]   <= ~bus.bus_rdata;
                NIB_MFG + 7'd2:    mfg_id[7:4]    <= ~bus.bus_rdata;
                NIB_MFG + 7'd3:    mfg_id[3:0]    <= ~bus.bus_rdata;
                NIB_SER:           serial[31:28]  <= ~bus.bus_rdata;
                NIB_SER + 7'd1:    serial[27:24]  <= ~bus.bus_rdata;
                NIB_SER + 7'd2:    serial[23:20]  <= ~bus.bus_rdata;
                NIB_SER + 7'd3:    serial[19:16]  <= ~bus.bus_rdata;
                NIB_SER + 7'd4:    serial[15:12]  <= ~bus.bus_rdata;
                NIB_SER + 7'd5:    serial[11:8]   <= ~bus.bus_rdata;
                NIB_SER + 7'd6:    serial[7:4]    <= ~bus.bus_rdata;
                NIB_SER + 7'd7:    serial[3:0]    <= ~bus.bus_rdata;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_autoconfig_host_scanner.sv
// Randomised bench for autoconfig_host_scanner against a behavioural Zorro III card.
module tb_autoconfig_host_scanner;

    localparam int unsigned TO = 16;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  base_nibble = 4'h0;
    logic        force_shutup = 1'b0;
    logic        cfgin_n = 1'b0;
    logic        busy, done, card_present, configured, timeout_err;
    logic [7:0]  er_type, prod_id, er_flags;
    logic [15:0] mfg_id;
    logic [31:0] serial;

    autoconfig_host_scanner_if bif ();

    autoconfig_host_scanner #(
        .TIMEOUT_CYCLES(TO),
        .LAST_NIBBLE   (7'h13)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .start       (start),
        .base_nibble (base_nibble),
        .force_shutup(force_shutup),
        .cfgin_n     (cfgin_n),
        .bus         (bif),
        .busy        (busy),
        .done        (done),
        .card_present(card_present),
        .configured  (configured),
        .timeout_err (timeout_err),
        .er_type     (er_type),
        .prod_id     (prod_id),
        .er_flags    (er_flags),
        .mfg_id      (mfg_id),
        .serial      (serial)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- behavioural card ----------------
    logic [3:0]  img [0:19];
    logic [71:0] card_exp;
    int unsigned max_delay = 0;
    int          never_ack = -1;
    int unsigned wait_cnt, wait_tgt;

    function automatic logic [6:0] nib_addr(input int unsigned i);
        logic [6:0] v;
        v = i[6:0];
        return {v[0], v[6:1]};
    endfunction

    function automatic int nib_of_addr(input logic [6:0] a);
        for (int i = 0; i < 20; i++) begin
            if (nib_addr(i) == a) return i;
        end
        return -1;
    endfunction

    always @(posedge CLK or posedge RESET) begin
        int idx;
        if (RESET) begin
            bif.bus_ack   <= 1'b0;
            bif.bus_rdata <= '0;
            wait_cnt      <= 0;
            wait_tgt      <= 0;
        end else if (!bif.bus_ack) begin
            idx = nib_of_addr(bif.bus_addrl);
            if (bif.bus_req && !(bif.bus_read && idx == never_ack)) begin
                if (wait_cnt >= wait_tgt) begin
                    bif.bus_ack   <= 1'b1;
                    bif.bus_rdata <= (bif.bus_read && idx >= 0) ? img[idx] : 4'h0;
                    wait_cnt      <= 0;
                    wait_tgt      <= $urandom_range(max_delay, 0);
                end else begin
                    wait_cnt <= wait_cnt + 1;
                end
            end
        end else if (!bif.bus_req) begin
            if (wait_cnt >= wait_tgt) begin
                bif.bus_ack <= 1'b0;
                wait_cnt    <= 0;
                wait_tgt    <= $urandom_range(max_delay, 0);
            end else begin
                wait_cnt <= wait_cnt + 1;
            end
        end
    end

    // ---------------- bus monitor ----------------
    logic [6:0]  rd_log [$];
    logic [10:0] wr_log [$];
    int          run_log [$];
    int          done_cnt = 0;
    int          run = 0;
    logic        prev_req = 1'b0;

    always @(negedge CLK) begin
        if (done) done_cnt++;
        if (bif.bus_req && !prev_req) begin
            if (bif.bus_read) rd_log.push_back(bif.bus_addrl);
            else wr_log.push_back({bif.bus_addrl, bif.bus_wdata});
        end
        if (bif.bus_req) run++;
        else if (prev_req) begin
            run_log.push_back(run);
            run = 0;
        end
        prev_req = bif.bus_req;
    end

    // ---------------- reference model ----------------
    task automatic load_card(input logic [7:0] t, input logic [7:0] p, input logic [7:0] f,
                             input logic [15:0] m, input logic [31:0] s);
        img[0] = t[7:4];
        img[1] = t[3:0];
        img[2] = ~p[7:4];
        img[3] = ~p[3:0];
        img[4] = ~f[7:4];
        img[5] = ~f[3:0];
        img[6] = 4'($urandom);
        img[7] = 4'($urandom);
        for (int k = 0; k < 4; k++) img[8 + k] = ~m[15 - 4 * k -: 4];
        for (int k = 0; k < 8; k++) img[12 + k] = ~s[31 - 4 * k -: 4];
        card_exp = {t, p, f, m, s};
    endtask

    function automatic logic [10:0] model_write(input logic [7:0] t, input logic sh,
                                                input logic [3:0] base);
        if (sh || t[7:6] != 2'b10) return {7'h13, 4'h0};
        return {7'h11, base};
    endfunction

    task automatic run_scan(input logic [3:0] base, input logic sh,
                            output int cycles, output bit timed_out);
        @(negedge CLK);
        base_nibble  = base;
        force_shutup = sh;
        start        = 1'b1;
        @(negedge CLK);
        start        = 1'b0;
        base_nibble  = 4'($urandom);
        force_shutup = 1'($urandom);
        cycles = 1;
        while (!done && cycles < 2000) begin
            @(negedge CLK);
            cycles++;
        end
        timed_out = !done;
    endtask

    task automatic settle();
        repeat (2) @(negedge CLK);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge CLK);
        n_tests++;
        if ({busy, done, card_present, configured, timeout_err, bif.bus_req} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 000000",
                     {busy, done, card_present, configured, timeout_err, bif.bus_req});
        end
        n_tests++;
        if ({bif.bus_read, bif.bus_addrl, bif.bus_wdata} !== {1'b1, 7'h00, 4'h0}) begin
            n_fail++;
            $display("FAIL reset_bus: got read=%b addrl=%h wdata=%h want 1/00/0",
                     bif.bus_read, bif.bus_addrl, bif.bus_wdata);
        end
        n_tests++;
        if ({er_type, prod_id, er_flags, mfg_id, serial} !== 72'h0) begin
            n_fail++;
            $display("FAIL reset_fields: got %h want 0", {er_type, prod_id, er_flags, mfg_id, serial});
        end
        RESET = 1'b0;
        settle();
    endtask

    task automatic test_configure();
        int cyc, rd0, wr0, d0;
        bit to, order_ok;
        load_card(8'hA4, 8'h72, 8'h30, 16'h07DB, 32'h000001A5);
        rd0 = rd_log.size(); wr0 = wr_log.size(); d0 = done_cnt;
        run_scan(4'h8, 1'b0, cyc, to);
        settle();
        n_tests++;
        if (to) begin n_fail++; $display("FAIL cfg_done: no done within budget"); end
        n_tests++;
        if ({er_type, prod_id, er_flags, mfg_id, serial} !== card_exp) begin
            n_fail++;
            $display("FAIL cfg_fields: got %h want %h", {er_type, prod_id, er_flags, mfg_id, serial}, card_exp);
        end
        order_ok = (rd_log.size() == rd0 + 20);
        for (int i = 0; i < 20 && order_ok; i++) order_ok = (rd_log[rd0 + i] == nib_addr(i));
        n_tests++;
        if (!order_ok) begin
            n_fail++;
            $display("FAIL cfg_read_order: got %0d reads want 20 in nibble order", rd_log.size() - rd0);
        end
        n_tests++;
        if (wr_log.size() != wr0 + 1 || wr_log[wr_log.size() - 1] !== {7'h11, 4'h8}) begin
            n_fail++;
            $display("FAIL cfg_write: got %0d writes last=%h want 1 write 11/8",
                     wr_log.size() - wr0, wr_log[wr_log.size() - 1]);
        end
        n_tests++;
        if ({configured, card_present, timeout_err, busy, done_cnt - d0} !== {4'b1100, 32'd1}) begin
            n_fail++;
            $display("FAIL cfg_status: got cfg=%b pres=%b to=%b busy=%b dones=%0d want 1 1 0 0 1",
                     configured, card_present, timeout_err, busy, done_cnt - d0);
        end
    endtask

    task automatic test_shutup(input logic [7:0] t, input logic sh, input string tag);
        int cyc, wr0;
        bit to;
        load_card(t, 8'h72, 8'h30, 16'h07DB, 32'h000001A5);
        wr0 = wr_log.size();
        run_scan(4'h8, sh, cyc, to);
        settle();
        n_tests++;
        if (to || wr_log.size() != wr0 + 1 || wr_log[wr_log.size() - 1] !== {7'h13, 4'h0}) begin
            n_fail++;
            $display("FAIL %s_write: got to=%b writes=%0d last=%h want 1 write 13/0",
                     tag, to, wr_log.size() - wr0, wr_log[wr_log.size() - 1]);
        end
        n_tests++;
        if ({configured, card_present, er_type} !== {2'b01, t}) begin
            n_fail++;
            $display("FAIL %s_status: got cfg=%b pres=%b type=%h want 0 1 %h",
                     tag, configured, card_present, er_type, t);
        end
    endtask

    task automatic test_no_card();
        int cyc, rd0, wr0, r0, d0;
        bit to;
        cfgin_n = 1'b1;
        rd0 = rd_log.size(); wr0 = wr_log.size(); r0 = run_log.size(); d0 = done_cnt;
        run_scan(4'h5, 1'b0, cyc, to);
        settle();
        n_tests++;
        if (to || cyc != 2) begin
            n_fail++;
            $display("FAIL nocard_latency: got %0d cycles (to=%b) want 2", cyc, to);
        end
        n_tests++;
        if (rd_log.size() != rd0 || wr_log.size() != wr0 || run_log.size() != r0 || done_cnt - d0 != 1) begin
            n_fail++;
            $display("FAIL nocard_bus: got accesses=%0d dones=%0d want 0 and 1",
                     rd_log.size() - rd0 + wr_log.size() - wr0, done_cnt - d0);
        end
        n_tests++;
        if ({card_present, configured, timeout_err} !== 3'b000) begin
            n_fail++;
            $display("FAIL nocard_status: got %b want 000", {card_present, configured, timeout_err});
        end
        cfgin_n = 1'b0;
    endtask

    task automatic test_random();
        for (int n = 0; n < 10; n++) begin
            int cyc, wr0;
            bit to;
            logic [7:0] t;
            logic [3:0] base;
            logic sh;
            logic [10:0] exp_wr;
            t = 8'($urandom);
            if ($urandom_range(3, 0) != 0) t[7:6] = 2'b10;
            sh = ($urandom_range(3, 0) == 0);
            base = 4'($urandom);
            max_delay = $urandom_range(3, 0);
            load_card(t, 8'($urandom), 8'($urandom), 16'($urandom), $urandom);
            exp_wr = model_write(t, sh, base);
            wr0 = wr_log.size();
            run_scan(base, sh, cyc, to);
            settle();
            n_tests++;
            if (to || {er_type, prod_id, er_flags, mfg_id, serial} !== card_exp) begin
                n_fail++;
                $display("FAIL rand%0d_fields: got %h want %h (to=%b)", n,
                         {er_type, prod_id, er_flags, mfg_id, serial}, card_exp, to);
            end
            n_tests++;
            if (wr_log.size() != wr0 + 1 || wr_log[wr_log.size() - 1] !== exp_wr ||
                {configured, card_present, timeout_err} !== {exp_wr[10:4] == 7'h11, 2'b10}) begin
                n_fail++;
                $display("FAIL rand%0d_write: got last=%h cfg=%b pres=%b to=%b want %h %b 1 0", n,
                         wr_log[wr_log.size() - 1], configured, card_present, timeout_err,
                         exp_wr, exp_wr[10:4] == 7'h11);
            end
        end
        max_delay = 0;
    endtask

    task automatic test_back_to_back();
        int cyc, wr0, d0;
        load_card(8'hA4, 8'h72, 8'h30, 16'h07DB, 32'h000001A5);
        wr0 = wr_log.size(); d0 = done_cnt;
        @(negedge CLK);
        base_nibble = 4'h8; force_shutup = 1'b0; start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        repeat (10) @(negedge CLK);
        base_nibble = 4'h3; force_shutup = 1'b1; start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        cyc = 0;
        while (!done && cyc < 2000) begin @(negedge CLK); cyc++; end
        settle();
        n_tests++;
        if (wr_log.size() != wr0 + 1 || wr_log[wr_log.size() - 1] !== {7'h11, 4'h8} ||
            configured !== 1'b1 || done_cnt - d0 != 1) begin
            n_fail++;
            $display("FAIL busy_start_ignored: got writes=%0d last=%h cfg=%b dones=%0d want 1 11/8 1 1",
                     wr_log.size() - wr0, wr_log[wr_log.size() - 1], configured, done_cnt - d0);
        end
    endtask

    task automatic test_timeout();
        int cyc, wr0, d0;
        bit to;
        load_card(8'hA4, 8'h72, 8'h30, 16'h07DB, 32'h000001A5);
        never_ack = 5;
        wr0 = wr_log.size(); d0 = done_cnt;
        run_scan(4'h8, 1'b0, cyc, to);
        settle();
        n_tests++;
        if (to || run_log[run_log.size() - 1] != TO) begin
            n_fail++;
            $display("FAIL timeout_req_len: got %0d cycles (to=%b) want %0d",
                     run_log[run_log.size() - 1], to, TO);
        end
        n_tests++;
        if ({timeout_err, card_present, configured, bif.bus_req} !== 4'b1000 ||
            wr_log.size() != wr0 || done_cnt - d0 != 1) begin
            n_fail++;
            $display("FAIL timeout_status: got to=%b pres=%b cfg=%b req=%b writes=%0d dones=%0d want 1 0 0 0 0 1",
                     timeout_err, card_present, configured, bif.bus_req, wr_log.size() - wr0, done_cnt - d0);
        end
        never_ack = -1;
    endtask

    task automatic test_reset_mid_scan();
        int cyc, wr0;
        bit to, found;
        load_card(8'hA4, 8'h72, 8'h30, 16'h07DB, 32'h000001A5);
        wr0 = wr_log.size();
        @(negedge CLK);
        base_nibble = 4'h8; force_shutup = 1'b0; start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 500 && !found; c++) begin
            if (bif.bus_req && bif.bus_addrl == nib_addr(9)) found = 1'b1;
            else @(negedge CLK);
        end
        #1 RESET = 1'b1;
        #1;
        n_tests++;
        if (!found || {bif.bus_req, busy, card_present} !== 3'b000) begin
            n_fail++;
            $display("FAIL midreset_abort: got found=%b req=%b busy=%b pres=%b want 1 0 0 0",
                     found, bif.bus_req, busy, card_present);
        end
        @(negedge CLK);
        RESET = 1'b0;
        run_scan(4'h8, 1'b0, cyc, to);
        settle();
        n_tests++;
        if (to || {er_type, prod_id, er_flags, mfg_id, serial} !== card_exp || configured !== 1'b1 ||
            wr_log.size() != wr0 + 1 || wr_log[wr_log.size() - 1] !== {7'h11, 4'h8}) begin
            n_fail++;
            $display("FAIL midreset_rescan: got fields=%h cfg=%b writes=%0d want %h 1 1",
                     {er_type, prod_id, er_flags, mfg_id, serial}, configured, wr_log.size() - wr0, card_exp);
        end
    endtask

    initial begin
        test_reset();
        test_configure();
        test_shutup(8'hA4, 1'b1, "forced");
        test_shutup(8'hC4, 1'b0, "z2");
        test_no_card();
        test_random();
        test_back_to_back();
        test_timeout();
        test_reset_mid_scan();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
